// File: rtl/gs_butterfly_if.sv
// gs_butterfly_if: operand/result valid-ready bundle for gs_butterfly.
// slave is the butterfly side, master is the producer/consumer side.
interface gs_butterfly_if;
    typedef logic [11:0] coeff_t;
    logic   in_valid_i;
    logic   in_ready_o;
    coeff_t a_i;
    coeff_t b_i;
    coeff_t zeta_i;
    logic   out_valid_o;
    logic   out_ready_i;
    coeff_t a_o;
    coeff_t b_o;
    modport slave (
        input  in_valid_i, a_i, b_i, zeta_i, out_ready_i,
        output in_ready_o, out_valid_o, a_o, b_o
    );
    modport master (
        output in_valid_i, a_i, b_i, zeta_i, out_ready_i,
        input  in_ready_o, out_valid_o, a_o, b_o
    );
endinterface

// File: rtl/gs_butterfly.sv
// gs_butterfly: 3-stage inverse-NTT Gentleman-Sande butterfly mod 3329 with valid/ready flow control.
// Define GS_HALVE_EN to scale both outputs by 2^-1 mod Q before the output register.
module gs_butterfly #(
    parameter int Q = 3329
) (
    input  logic          clk,
    input  logic          rst_n,
    gs_butterfly_if.slave bus
);
    if (Q != 3329) begin : g_q_check
        $error("gs_butterfly: only Q=3329 is supported");
    end

    localparam logic [12:0] QW = 13'(Q);
    // floor(2^24/Q); with products below 2^24 the Barrett remainder lands in 0..2Q-1
    localparam int unsigned BARRETT_M = (1 << 24) / Q;

    logic        en;
    logic        v1, v2, v3;
    logic [11:0] s1_sum, s1_diff, s1_zeta, s2_sum, a_q, b_q;
    logic [23:0] s2_prod;
    logic [12:0] sum_w, diff_w, br;
    logic [11:0] sum_n, diff_n, bt, prod_red, a_n, b_n;

    assign en             = !v3 || bus.out_ready_i;
    assign bus.in_ready_o = en;
    assign bus.out_valid_o = v3;
    assign bus.a_o        = a_q;
    assign bus.b_o        = b_q;

    assign sum_w  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    assign diff_w = {1'b0, bus.b_i} + QW - {1'b0, bus.a_i};
    assign sum_n  = sum_w >= QW ? 12'(sum_w - QW) : sum_w[11:0];
    assign diff_n = diff_w >= QW ? 12'(diff_w - QW) : diff_w[11:0];

    assign bt       = 12'((37'(s2_prod) * 37'(BARRETT_M)) >> 24);
    assign br       = 13'(s2_prod - 24'(bt) * 24'(Q));
    assign prod_red = br >= QW ? 12'(br - QW) : br[11:0];

`ifdef GS_HALVE_EN
    function automatic logic [11:0] halve(input logic [11:0] x);
        return 12'(({1'b0, x} + (x[0] ? QW : 13'd0)) >> 1);
    endfunction
    assign a_n = halve(s2_sum);
    assign b_n = halve(prod_red);
`else
    assign a_n = s2_sum;
    assign b_n = prod_red;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_sum  <= '0;
            s1_diff <= '0;
            s1_zeta <= '0;
            s2_sum  <= '0;
            s2_prod <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (en) begin
            v1      <= bus.in_valid_i;
            s1_sum  <= sum_n;
            s1_diff <= diff_n;
            s1_zeta <= bus.zeta_i;
            v2      <= v1;
            s2_sum  <= s1_sum;
            s2_prod <= 24'(s1_diff) * 24'(s1_zeta);
            v3      <= v2;
            a_q     <= a_n;
            b_q     <= b_n;
        end
    end
endmodule

// File: tb/tb_gs_butterfly.sv
// tb_gs_butterfly: randomized scoreboard bench for gs_butterfly, plus directed latency,
// backpressure and mid-flight reset cases; reference uses plain modular arithmetic.
module tb_gs_butterfly;
    localparam int Q = 3329;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0, n_fail = 0, n_acc = 0, n_out = 0;
    int   qa[$], qb[$];
    int   acc_base, out_base;
    int   bpa[5], bpb[5], bpz[5];
    int   da[3] = '{100, 3328, 5};
    int   db[3] = '{200, 1, 10};
    int   dz[3] = '{1, 17, 3328};
`ifdef GS_HALVE_EN
    int   ea[3] = '{150, 0, 1672};
    int   eb[3] = '{50, 17, 1662};
`else
    int   ea[3] = '{300, 0, 15};
    int   eb[3] = '{100, 34, 3324};
`endif
    bit   done;

    gs_butterfly_if bus();
    gs_butterfly #(.Q(Q)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int scale(input int x);
`ifdef GS_HALVE_EN
        return (x * 1665) % Q;
`else
        return x;
`endif
    endfunction

    function automatic int ref_a(input int a, input int b);
        return scale((a + b) % Q);
    endfunction

    function automatic int ref_b(input int a, input int b, input int z);
        return scale((z * ((b - a + Q) % Q)) % Q);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input int z);
        int t = 0;
        bus.in_valid_i = 1'b1;
        bus.a_i = 12'(a);
        bus.b_i = 12'(b);
        bus.zeta_i = 12'(z);
        @(negedge clk);
        while (!bus.in_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drive_timeout", t, 0);
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
    endtask

    // Scoreboard: sampled mid-cycle, so it sees exactly what the next edge transfers
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_out++;
                if (qa.size() == 0) check("unexpected_output", int'(bus.out_valid_o), 0);
                else begin
                    check("sb_a", int'(bus.a_o), qa.pop_front());
                    check("sb_b", int'(bus.b_o), qb.pop_front());
                end
            end
            if (bus.in_valid_i && bus.in_ready_o) begin
                n_acc++;
                qa.push_back(ref_a(int'(bus.a_i), int'(bus.b_i)));
                qb.push_back(ref_b(int'(bus.a_i), int'(bus.b_i), int'(bus.zeta_i)));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid_i = 1'b0;
        bus.a_i = '0;
        bus.b_i = '0;
        bus.zeta_i = '0;
        bus.out_ready_i = 1'b1;
        #1;
        check("rst_out_valid", int'(bus.out_valid_o), 0);
        check("rst_a_o", int'(bus.a_o), 0);
        check("rst_b_o", int'(bus.b_o), 0);
        check("rst_in_ready", int'(bus.in_ready_o), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 check("in_ready_after_rst", int'(bus.in_ready_o), 1);

        for (int i = 0; i < 3; i++) begin
            drive(da[i], db[i], dz[i]);
            @(negedge clk) check("lat_c1", int'(bus.out_valid_o), 0);
            @(negedge clk) check("lat_c2", int'(bus.out_valid_o), 0);
            @(negedge clk) check("lat_c3", int'(bus.out_valid_o), 1);
            check("dir_a_o", int'(bus.a_o), ea[i]);
            check("dir_b_o", int'(bus.b_o), eb[i]);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 5; i++) begin
            bpa[i] = int'($urandom_range(Q - 1, 0));
            bpb[i] = int'($urandom_range(Q - 1, 0));
            bpz[i] = int'($urandom_range(Q - 1, 0));
        end
        bus.out_ready_i = 1'b0;
        acc_base = n_acc;
        out_base = n_out;
        fork
            for (int i = 0; i < 5; i++) drive(bpa[i], bpb[i], bpz[i]);
            begin
                repeat (6) @(negedge clk);
                check("bp_in_ready", int'(bus.in_ready_o), 0);
                check("bp_accepted", n_acc - acc_base, 3);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_hold_valid", int'(bus.out_valid_o), 1);
                    check("bp_hold_a", int'(bus.a_o), ref_a(bpa[0], bpb[0]));
                    check("bp_hold_b", int'(bus.b_o), ref_b(bpa[0], bpb[0], bpz[0]));
                end
                @(posedge clk);
                #1 bus.out_ready_i = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("bp_outputs", n_out - out_base, 5);
        check("bp_sb_empty", qa.size(), 0);

        out_base = n_out;
        drive(11, 22, 33);
        drive(44, 55, 66);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid_o), 0);
        check("midrst_a_o", int'(bus.a_o), 0);
        check("midrst_b_o", int'(bus.b_o), 0);
        check("midrst_in_ready", int'(bus.in_ready_o), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", n_out - out_base, 0);

        acc_base = n_acc;
        out_base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(3, 0) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    drive(int'($urandom_range(Q - 1, 0)), int'($urandom_range(Q - 1, 0)),
                          int'($urandom_range(Q - 1, 0)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready_i = ($urandom_range(2, 0) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rnd_accepted", n_acc - acc_base, 1000);
        check("rnd_outputs", n_out - out_base, 1000);
        check("rnd_sb_empty", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gs_butterfly.md
GS_BUTTERFLY -- requirements
Module: gs_butterfly

Interface
REQ-001 SHALL have parameter Q, default 3329, the modulus; only 3329 is supported, and any other value SHALL fail elaboration.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i  input  1  an operand triple is presented.
REQ-005 SHALL have port in_ready_o  output  1  the block accepts the triple this cycle.
REQ-006 SHALL have port a_i  input  coeff_t (12)  lower coefficient f[j], range 0..Q-1.
REQ-007 SHALL have port b_i  input  coeff_t (12)  upper coefficient f[j+len], range 0..Q-1.
REQ-008 SHALL have port zeta_i  input  coeff_t (12)  twiddle factor, range 0..Q-1.
REQ-009 SHALL have port out_valid_o  output  1  a result pair is presented.
REQ-010 SHALL have port out_ready_i  input  1  the consumer takes the result pair.
REQ-011 SHALL have port a_o  output  coeff_t (12)  result (a+b) mod Q.
REQ-012 SHALL have port b_o  output  coeff_t (12)  result (zeta*(b-a)) mod Q.

Function
REQ-013 SHALL implement the inverse-NTT Gentleman-Sande butterfly, the inverse of the forward Cooley-Tukey butterfly.
REQ-014 SHALL transfer input when in_valid_i && in_ready_o, and transfer output when out_valid_o && out_ready_i.
REQ-015 SHALL be a 3-stage pipeline with a valid bit per stage:
  - S1: registers sum=(a+b) mod Q and diff=(b-a+Q) mod Q, and zeta.
  - S2: registers sum and the 24-bit product diff*zeta.
  - S3: registers a_o=sum and b_o=Barrett-reduced product, fully reduced to 0..Q-1.
REQ-016 SHALL have a latency of exactly 3 cycles from acceptance to out_valid_o when unstalled, and a throughput of 1 per cycle.
REQ-017 SHALL use a global advance enable = !v3 || out_ready_i, and SHALL drive in_ready_o = enable combinationally.
REQ-018 When the enable is low, SHALL hold all stage registers and valids, with a_o/b_o stable while out_valid_o=1.
REQ-019 SHALL fill all 3 stages and then deassert in_ready_o while out_ready_i=0; no data is lost or duplicated.
REQ-020 SHALL let a bubble (in_valid_i=0 while enabled) propagate as valid=0; data in invalid stages is don't-care.
REQ-021 SHALL perform simultaneous input and output transfer in the same cycle when full with out_ready_i=1.
REQ-022 SHALL use intermediate widths of 13 bits for sum/diff before correction and 24 bits for the product; no truncation before reduction.
REQ-023 SHALL produce Q-1 and 0 correctly at boundaries, e.g. a=Q-1, b=1 gives a_o=0.

Reset
REQ-024 SHALL clear all stage valids to 0 immediately on rst_n low, so out_valid_o=0, a_o=0 and b_o=0.
REQ-025 SHALL drive in_ready_o=1 during and after reset.
REQ-026 SHALL discard in-flight operations on a mid-operation reset, and produce no output for them after release.

Configuration
REQ-027 With macro GS_HALVE_EN defined, SHALL multiply both outputs by 2^-1 mod Q at S3 input: x even gives x/2, x odd gives (x+Q)/2; latency unchanged.
REQ-028 Without GS_HALVE_EN, SHALL pass outputs unscaled and instantiate no halving logic.

Verification
REQ-029 SHALL cover a=100, b=200, zeta=1, giving a_o=300, b_o=100 after 3 cycles; with GS_HALVE_EN, 150 and 50.
REQ-030 SHALL cover a=3328, b=1, zeta=17, giving a_o=0, b_o=34; with GS_HALVE_EN, 0 and 17.
REQ-031 SHALL cover a=5, b=10, zeta=3328, giving a_o=15, b_o=3324; with GS_HALVE_EN, 1672 and 1662.
REQ-032 SHALL cover backpressure: out_ready_i=0 while driving 5 triples, giving in_ready_o=0 after 3 accepted and outputs stable; releasing out_ready_i then yields all 5 results in order with none lost.
REQ-033 SHALL cover reset: rst_n pulsed low with 2 operations in flight, giving out_valid_o=0 immediately and no stale results after release.
REQ-034 SHALL cover 1000 random triples (0..3328) with random in_valid_i/out_ready_i, checked against a scoreboard model with zero mismatches.
